// File: rtl/apb_ahb_if_multi.sv
// AHB-Lite slave to APB4 master bridge driving NUM_SLV one-hot selected APB slaves.
// Optional macro APB_TIMEOUT_EN aborts an APB access that waits TIMEOUT_CYC cycles without pready.
//
// state  | meaning
// IDLE   | no transfer, ready to accept
// WDATA  | write accepted, capturing hwdata from the AHB data phase
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, waiting for pready of the selected slave
// DONE   | transfer completed OKAY, may accept the next one
// ERR1   | first ERROR response cycle (hreadyout=0)
// ERR2   | second ERROR response cycle (hreadyout=1), may accept the next one
module apb_ahb_if_multi #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SLV     = 4,
  parameter int SLV_LSB     = 12,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic                          hsel,
  input  logic [ADDR_WIDTH-1:0]         haddr,
  input  logic [1:0]                    htrans,
  input  logic                          hwrite,
  input  logic [2:0]                    hsize,
  input  logic [DATA_WIDTH-1:0]         hwdata,
  input  logic                          hready,
  output logic                          hreadyout,
  output logic                          hresp,
  output logic [DATA_WIDTH-1:0]         hrdata,
  output logic [NUM_SLV-1:0]            psel,
  output logic                          penable,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic                          pwrite,
  output logic [DATA_WIDTH-1:0]         pwdata,
  output logic [DATA_WIDTH/8-1:0]       pstrb,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLV-1:0]            pready,
  input  logic [NUM_SLV-1:0]            pslverr
);

  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int BW = DATA_WIDTH / 8;
  localparam int BL = $clog2(BW);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         idx_q;
  logic [SW-1:0]         dec_idx;
  logic [SW-1:0]         sel_idx;
  logic [BL-1:0]         lane;
  logic [4:0]            nbytes;
  logic [BW-1:0]         strb_calc;
  logic                  dec_err;
  logic                  can_accept;
  logic                  valid;
  logic                  pready_sel;
  logic                  pslverr_sel;
  logic [DATA_WIDTH-1:0] prdata_sel;
  logic                  tmo_hit;
  logic                  unused_ok;

  assign unused_ok = htrans[0];

  // Address-phase decode: slave index, size/alignment legality and write strobes.
  always_comb begin
    dec_idx   = haddr[SLV_LSB +: SW];
    lane      = haddr[BL-1:0];
    nbytes    = 5'd1 << hsize;
    dec_err   = (int'(dec_idx) >= NUM_SLV) || (hsize > 3'(BL)) ||
                ((lane & BL'(nbytes - 5'd1)) != '0);
    strb_calc = '0;
    for (int i = 0; i < BW; i++) begin
      strb_calc[i] = (i >= int'(lane)) && (i < int'(lane) + int'(nbytes));
    end
  end

  assign can_accept  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
  assign valid       = hsel & hready & htrans[1];
  assign sel_idx     = can_accept ? dec_idx : idx_q;
  assign pready_sel  = pready[idx_q];
  assign pslverr_sel = pslverr[idx_q];
  assign prdata_sel  = prdata[idx_q*DATA_WIDTH +: DATA_WIDTH];

`ifdef APB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      tmo_cnt <= '0;
    end else if (state_d == S_SETUP) begin
      tmo_cnt <= '0;
    end else if ((state_q == S_ACCESS) && !pready_sel) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // Hit on the TIMEOUT_CYC-th ACCESS cycle that still sees no pready.
  assign tmo_hit = (state_q == S_ACCESS) && (tmo_cnt == 16'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (valid) begin
          if (dec_err)     state_d = S_ERR1;
          else if (hwrite) state_d = S_WDATA;
          else             state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WDATA:  state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (pready_sel)   state_d = pslverr_sel ? S_ERR1 : S_DONE;
        else if (tmo_hit) state_d = S_ERR1;
      end
      S_ERR1:   state_d = S_ERR2;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output leaves a flop.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
    end else begin
      state_q   <= state_d;
      hreadyout <= (state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR2);
      hresp     <= (state_d == S_ERR1) || (state_d == S_ERR2);
      penable   <= (state_d == S_ACCESS);
      psel      <= ((state_d == S_SETUP) || (state_d == S_ACCESS)) ?
                   (NUM_SLV'(1) << sel_idx) : '0;
      if (can_accept && valid && !dec_err) begin
        idx_q  <= dec_idx;
        paddr  <= haddr;
        pwrite <= hwrite;
        pstrb  <= hwrite ? strb_calc : '0;
      end
      if (state_q == S_WDATA) begin
        pwdata <= hwdata;
      end
      if ((state_q == S_ACCESS) && pready_sel && !pslverr_sel && !pwrite) begin
        hrdata <= prdata_sel;
      end
    end
  end

endmodule

// File: tb/tb_apb_ahb_if_multi.sv
// Directed bench for apb_ahb_if_multi: vector table of single transfers plus hand sequences
// for wait states, back-to-back transfers, decode errors on a 3-slave build, timeout and reset.
module tb_apb_ahb_if_multi;

  logic         hclk = 1'b0;
  logic         hreset;
  logic         hsel, hsel3;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hwrite;
  logic [2:0]   hsize;
  logic [31:0]  hwdata;
  logic         hready, hready3;
  logic         hreadyout, hresp;
  logic [31:0]  hrdata;
  logic [3:0]   psel;
  logic         penable;
  logic [31:0]  paddr;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [127:0] prdata;
  logic [3:0]   pready, pslverr;

  logic         hreadyout3, hresp3, penable3, pwrite3;
  logic [31:0]  hrdata3, paddr3, pwdata3;
  logic [2:0]   psel3;
  logic [3:0]   pstrb3;
  logic [95:0]  prdata3;
  logic [2:0]   pready3, pslverr3;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  assign hready  = hreadyout;
  assign hready3 = hreadyout3;
  assign prdata3  = '0;
  assign pready3  = '1;
  assign pslverr3 = '0;

  apb_ahb_if_multi #(.NUM_SLV(4), .TIMEOUT_CYC(8)) u_dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .psel(psel),
    .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_ahb_if_multi #(.NUM_SLV(3), .TIMEOUT_CYC(8)) u_dut3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready3),
    .hreadyout(hreadyout3), .hresp(hresp3), .hrdata(hrdata3), .psel(psel3),
    .penable(penable3), .paddr(paddr3), .pwrite(pwrite3), .pwdata(pwdata3),
    .pstrb(pstrb3), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        slverr;
    logic [3:0]  e_psel;
    logic [3:0]  e_strb;
    int          e_waits;
    logic        e_resp;
    logic [31:0] e_hrdata;
  } vec_t;

  vec_t vecs[9];

  int          r_waits, r_psel_cyc, r_pen_cyc;
  logic [3:0]  r_psel_or, r_strb;
  logic [31:0] r_wdata, r_paddr;
  logic        r_resp_end, r_resp_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_slaves(input int sel, input logic [31:0] rdata, input logic err);
    for (int i = 0; i < 4; i++) begin
      prdata[i*32 +: 32] = (i == sel) ? rdata : (32'hDEAD_0000 | 32'(i));
      pslverr[i]         = (i == sel) ? err : 1'b1;
    end
  endtask

  // One AHB transfer; pready stays low for low_cyc ACCESS cycles, then rises.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input int low_cyc);
    logic done;
    pready = (low_cyc == 0) ? 4'hF : 4'h0;
    @(negedge hclk);
    hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = wr; hsize = size;
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
    r_waits = 0; r_psel_cyc = 0; r_pen_cyc = 0; r_psel_or = '0; r_strb = '0;
    r_wdata = '0; r_paddr = '0; r_resp_last = 1'b0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge hclk);
      if (psel != '0) begin
        r_psel_or |= psel; r_psel_cyc++; r_strb = pstrb; r_paddr = paddr;
      end
      if (penable) begin
        r_pen_cyc++; r_wdata = pwdata;
        if (r_pen_cyc > low_cyc) pready = 4'hF;
      end
      if (hreadyout) done = 1'b1;
      else begin
        r_waits++; r_resp_last = hresp;
      end
    end
    r_resp_end = hresp;
    chk("xfer_completes", 64'(done), 64'd1);
    pready = 4'hF;
  endtask

  initial begin
    int w;
    logic [3:0] po;
    logic [31:0] wc;

    //          wr    addr          sz    wdata          rdata          err   psel     strb     waits resp  hrdata
    vecs[0] = '{1'b0, 32'h0000_2004, 3'd2, 32'h0,         32'hA5A5_0001, 1'b0, 4'b0100, 4'b0000, 2, 1'b0, 32'hA5A5_0001};
    vecs[1] = '{1'b1, 32'h0000_1003, 3'd0, 32'h1100_0000, 32'h0,         1'b0, 4'b0010, 4'b1000, 3, 1'b0, 32'hA5A5_0001};
    vecs[2] = '{1'b1, 32'h0000_0002, 3'd1, 32'hBEEF_0000, 32'h0,         1'b0, 4'b0001, 4'b1100, 3, 1'b0, 32'hA5A5_0001};
    vecs[3] = '{1'b1, 32'h0000_3008, 3'd2, 32'h1234_5678, 32'h0,         1'b0, 4'b1000, 4'b1111, 3, 1'b0, 32'hA5A5_0001};
    vecs[4] = '{1'b0, 32'h0000_0010, 3'd2, 32'h0,         32'h0BAD_F00D, 1'b0, 4'b0001, 4'b0000, 2, 1'b0, 32'h0BAD_F00D};
    vecs[5] = '{1'b0, 32'h0000_1000, 3'd2, 32'h0,         32'h7777_7777, 1'b1, 4'b0010, 4'b0000, 3, 1'b1, 32'h0BAD_F00D};
    vecs[6] = '{1'b1, 32'h0000_2001, 3'd2, 32'h5555_5555, 32'h0,         1'b0, 4'b0000, 4'b0000, 1, 1'b1, 32'h0BAD_F00D};
    vecs[7] = '{1'b0, 32'h0000_2000, 3'd3, 32'h0,         32'h0,         1'b0, 4'b0000, 4'b0000, 1, 1'b1, 32'h0BAD_F00D};
    vecs[8] = '{1'b0, 32'h0000_3003, 3'd0, 32'h0,         32'hCAFE_0077, 1'b0, 4'b1000, 4'b0000, 2, 1'b0, 32'hCAFE_0077};

    hreset = 1'b1; hsel = 1'b0; hsel3 = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd0; hwdata = '0; pready = 4'hF; pslverr = '0; prdata = '0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_hreadyout", 64'(hreadyout), 64'd1);
    chk("rst_hresp",     64'(hresp),     64'd0);
    chk("rst_hrdata",    64'(hrdata),    64'd0);
    chk("rst_psel",      64'(psel),      64'd0);
    chk("rst_penable",   64'(penable),   64'd0);
    chk("rst_paddr",     64'(paddr),     64'd0);
    chk("rst_pwrite",    64'(pwrite),    64'd0);
    chk("rst_pwdata",    64'(pwdata),    64'd0);
    chk("rst_pstrb",     64'(pstrb),     64'd0);
    hreset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      set_slaves(int'(vecs[i].addr[13:12]), vecs[i].rdata, vecs[i].slverr);
      do_xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, 0);
      chk($sformatf("v%0d_psel", i),     64'(r_psel_or),   64'(vecs[i].e_psel));
      chk($sformatf("v%0d_psel_cyc", i), 64'(r_psel_cyc),  (vecs[i].e_psel != '0) ? 64'd2 : 64'd0);
      chk($sformatf("v%0d_pstrb", i),    64'(r_strb),      64'(vecs[i].e_strb));
      chk($sformatf("v%0d_waits", i),    64'(r_waits),     64'(vecs[i].e_waits));
      chk($sformatf("v%0d_hresp", i),    64'(r_resp_end),  64'(vecs[i].e_resp));
      chk($sformatf("v%0d_err1", i),     64'(r_resp_last), 64'(vecs[i].e_resp));
      chk($sformatf("v%0d_hrdata", i),   64'(hrdata),      64'(vecs[i].e_hrdata));
      if (vecs[i].e_psel != '0) chk($sformatf("v%0d_paddr", i), 64'(r_paddr), 64'(vecs[i].addr));
      if (vecs[i].wr && vecs[i].e_psel != '0) chk($sformatf("v%0d_pwdata", i), 64'(r_wdata), 64'(vecs[i].wdata));
    end

    // Write with 3 low-pready ACCESS cycles ending in pslverr
    set_slaves(1, 32'h0, 1'b1);
    do_xfer(1'b1, 32'h0000_1000, 3'd2, 32'h7777_0000, 3);
    chk("t3_access_cyc", 64'(r_pen_cyc),   64'd4);
    chk("t3_waits",      64'(r_waits),     64'd7);
    chk("t3_psel",       64'(r_psel_or),   64'b0010);
    chk("t3_pwdata",     64'(r_wdata),     64'h7777_0000);
    chk("t3_err1_hresp", 64'(r_resp_last), 64'd1);
    chk("t3_err2_hresp", 64'(r_resp_end),  64'd1);
    chk("t3_hrdata",     64'(hrdata),      64'hCAFE_0077);

    // Decode error on the 3-slave build: index 3 does not exist
    @(negedge hclk);
    hsel3 = 1'b1; haddr = 32'h0000_3000; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    @(posedge hclk);
    #1;
    hsel3 = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    chk("t4_err1_ready", 64'(hreadyout3), 64'd0);
    chk("t4_err1_hresp", 64'(hresp3),     64'd1);
    chk("t4_err1_psel",  64'(psel3),      64'd0);
    @(negedge hclk);
    chk("t4_err2_ready", 64'(hreadyout3), 64'd1);
    chk("t4_err2_hresp", 64'(hresp3),     64'd1);
    chk("t4_err2_psel",  64'(psel3),      64'd0);
    @(negedge hclk);
    chk("t4_idle_hresp", 64'(hresp3),     64'd0);

    // Back-to-back read then write, second accepted in DONE
    set_slaves(2, 32'h5555_AAAA, 1'b0);
    pslverr = '0;
    @(negedge hclk);
    hsel = 1'b1; haddr = 32'h0000_2008; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = 2'b00;
    w = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge hclk);
      if (hreadyout) break;
      w++;
    end
    chk("t5_rd_waits",  64'(w),      64'd2);
    chk("t5_rd_hrdata", 64'(hrdata), 64'h5555_AAAA);
    hsel = 1'b1; haddr = 32'h0000_3004; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h600D_CAFE;
    @(negedge hclk);
    chk("t5_no_idle", 64'(hreadyout), 64'd0);
    w = 1; po = '0; wc = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge hclk);
      if (psel != '0) po |= psel;
      if (penable) wc = pwdata;
      if (hreadyout) break;
      w++;
    end
    chk("t5_wr_waits",  64'(w),     64'd3);
    chk("t5_wr_psel",   64'(po),    64'b1000);
    chk("t5_wr_pwdata", 64'(wc),    64'h600D_CAFE);
    chk("t5_wr_pstrb",  64'(pstrb), 64'hF);
    chk("t5_wr_hresp",  64'(hresp), 64'd0);

`ifdef APB_TIMEOUT_EN
    set_slaves(0, 32'h0, 1'b0);
    do_xfer(1'b0, 32'h0000_0000, 3'd2, 32'h0, 1000);
    chk("t6_tmo_access", 64'(r_pen_cyc),   64'd8);
    chk("t6_tmo_waits",  64'(r_waits),     64'd10);
    chk("t6_tmo_err1",   64'(r_resp_last), 64'd1);
    chk("t6_tmo_hresp",  64'(r_resp_end),  64'd1);
`endif

    // Stuck pready, then reset in the middle of ACCESS
    set_slaves(0, 32'h0, 1'b0);
    pready = 4'h0;
    @(negedge hclk);
    hsel = 1'b1; haddr = 32'h0000_0000; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = 2'b00;
`ifdef APB_TIMEOUT_EN
    repeat (4) @(negedge hclk);
`else
    repeat (100) @(negedge hclk);
`endif
    chk("t6_wait_ready",   64'(hreadyout), 64'd0);
    chk("t6_wait_penable", 64'(penable),   64'd1);
    chk("t6_wait_psel",    64'(psel),      64'b0001);
    hreset = 1'b1;
    @(negedge hclk);
    chk("t6_rst_psel",    64'(psel),      64'd0);
    chk("t6_rst_penable", 64'(penable),   64'd0);
    chk("t6_rst_ready",   64'(hreadyout), 64'd1);
    chk("t6_rst_hrdata",  64'(hrdata),    64'd0);
    hreset = 1'b0;
    pready = 4'hF;

    set_slaves(2, 32'h1357_9BDF, 1'b0);
    do_xfer(1'b0, 32'h0000_2000, 3'd2, 32'h0, 0);
    chk("post_rst_hrdata", 64'(hrdata),  64'h1357_9BDF);
    chk("post_rst_waits",  64'(r_waits), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
